// File: rtl/alu_muldiv_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_muldiv_sequencer_pkg
// Brief  : Shared Alu opcodes, sequencer op codes and FSM state encodings.
// Rev    : 1.0  initial release
// ============================================================================
package alu_muldiv_sequencer_pkg;

  localparam int c_WIDTH = 16;

  localparam logic [3:0] c_ALU_ADD = 4'd0;
  localparam logic [3:0] c_ALU_SUB = 4'd1;
  localparam logic [3:0] c_ALU_AND = 4'd2;
  localparam logic [3:0] c_ALU_OR  = 4'd3;
  localparam logic [3:0] c_ALU_XOR = 4'd4;

  localparam logic c_OP_MUL = 1'b0;
  localparam logic c_OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : alu_muldiv_sequencer_if
// Brief  : CPU request/result handshake plus the borrowed Alu operand bus.
// Rev    : 1.0  initial release
// ============================================================================
interface alu_muldiv_sequencer_if
  import alu_muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = c_WIDTH
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;
  logic             alu_active;
  logic [WIDTH-1:0] alu_operand1;
  logic [WIDTH-1:0] alu_operand2;
  logic [3:0]       alu_operation;
  logic [WIDTH-1:0] alu_result;

  // CPU side plus the Alu returning its result
  modport master (
    output start, op, operand_a, operand_b, alu_result,
    input  busy, done, div_by_zero, result_hi, result_lo,
    input  alu_active, alu_operand1, alu_operand2, alu_operation
  );

  modport slave (
    input  start, op, operand_a, operand_b, alu_result,
    output busy, done, div_by_zero, result_hi, result_lo,
    output alu_active, alu_operand1, alu_operand2, alu_operation
  );
endinterface
`default_nettype wire

// File: rtl/alu_muldiv_sequencer_alu.sv
`default_nettype none
// ============================================================================
// Module : alu_muldiv_sequencer_alu
// Brief  : Shared combinational Alu (ADD/SUB/AND/OR/XOR) borrowed by the sequencer.
// Rev    : 1.0  initial release
// ============================================================================
module alu_muldiv_sequencer_alu
  import alu_muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = c_WIDTH
) (
  input  wire logic [WIDTH-1:0] operand1,
  input  wire logic [WIDTH-1:0] operand2,
  input  wire logic [3:0]       operation,
  output logic      [WIDTH-1:0] result
);
  always_comb begin
    result = '0;
    case (operation)
      c_ALU_ADD: result = operand1 + operand2;
      c_ALU_SUB: result = operand1 - operand2;
      c_ALU_AND: result = operand1 & operand2;
      c_ALU_OR:  result = operand1 | operand2;
      c_ALU_XOR: result = operand1 ^ operand2;
      default:   result = '0;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/alu_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module : alu_muldiv_sequencer
// Brief  : Unsigned multiply / restoring divide, one bit per cycle on the shared Alu.
// Rev    : 1.0  initial release
// ============================================================================
module alu_muldiv_sequencer
  import alu_muldiv_sequencer_pkg::*;
#(
  parameter int               WIDTH         = c_WIDTH,
  parameter logic [WIDTH-1:0] DIV0_QUOTIENT = 16'hFFFF
) (
  input  wire logic              clk,
  input  wire logic              reset,
  alu_muldiv_sequencer_if.slave  bus
);
  localparam int                 c_CNT_W    = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic               r_op;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_lo;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_dbz;

  logic             w_b_zero;
  logic             w_msb;
  logic [WIDTH-1:0] w_rs;
  logic             w_carry;
  logic             w_sub_ok;

  assign w_b_zero = (bus.operand_b == '0);
  // Divide: partial remainder is acc shifted left with the next dividend bit
  assign w_msb    = r_acc[WIDTH-1];
  assign w_rs     = {r_acc[WIDTH-2:0], r_lo[WIDTH-1]};
  assign w_sub_ok = w_msb | (w_rs >= r_b);
  assign w_carry  = (bus.alu_result < r_acc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state      = r_state;
    bus.alu_active    = 1'b0;
    bus.alu_operand1  = '0;
    bus.alu_operand2  = '0;
    bus.alu_operation = c_ALU_ADD;
    case (r_state)
      S_IDLE: begin
        if (bus.start)
          w_next_state = (bus.op == c_OP_DIV && w_b_zero) ? S_FINISH : S_RUN;
      end
      S_RUN: begin
        bus.alu_active    = 1'b1;
        bus.alu_operand1  = (r_op == c_OP_DIV) ? w_rs : r_acc;
        bus.alu_operand2  = r_b;
        bus.alu_operation = (r_op == c_OP_DIV) ? c_ALU_SUB : c_ALU_ADD;
        if (r_cnt == c_CNT_LAST) w_next_state = S_FINISH;
      end
      S_FINISH: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op  <= c_OP_MUL;
      r_b   <= '0;
      r_acc <= '0;
      r_lo  <= '0;
      r_cnt <= '0;
      r_dbz <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_op  <= bus.op;
            r_b   <= bus.operand_b;
            r_cnt <= '0;
            r_dbz <= (bus.op == c_OP_DIV) && w_b_zero;
            if (bus.op == c_OP_DIV && w_b_zero) begin
              r_acc <= bus.operand_a;
              r_lo  <= DIV0_QUOTIENT;
            end else begin
              r_acc <= '0;
              r_lo  <= bus.operand_a;
            end
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_op == c_OP_MUL) begin
            // Shift-add: the carry out of acc+multiplicand re-enters at the top
            if (r_lo[0]) begin
              r_acc <= {w_carry, bus.alu_result[WIDTH-1:1]};
              r_lo  <= {bus.alu_result[0], r_lo[WIDTH-1:1]};
            end else begin
              r_acc <= {1'b0, r_acc[WIDTH-1:1]};
              r_lo  <= {r_acc[0], r_lo[WIDTH-1:1]};
            end
          end else begin
            r_acc <= w_sub_ok ? bus.alu_result : w_rs;
            r_lo  <= {r_lo[WIDTH-2:0], w_sub_ok};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = (r_state == S_FINISH);
  assign bus.div_by_zero = r_dbz;
  assign bus.result_hi   = r_acc;
  assign bus.result_lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_muldiv_sequencer
// Brief  : Directed self-checking bench for the sequencer wired to the shared Alu.
// Rev    : 1.0  initial release
// ============================================================================
module tb_alu_muldiv_sequencer;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  int          lat;
  int          busy_n;
  logic        alu_seen;
  logic [3:0]  first_aluop;
  logic        got_done;
  logic [31:0] res;
  logic        dbz;
  logic        post_busy;
  logic        post_done;

  alu_muldiv_sequencer_if bus ();

  alu_muldiv_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  alu_muldiv_sequencer_alu u_alu (
    .operand1  (bus.alu_operand1),
    .operand2  (bus.alu_operand2),
    .operation (bus.alu_operation),
    .result    (bus.alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request and follow it to done; optionally pulse a second start mid-flight
  task automatic run_op(input logic opv, input logic [15:0] a, input logic [15:0] b,
                        input int inject_at);
    @(negedge clk);
    bus.start = 1'b1; bus.op = opv; bus.operand_a = a; bus.operand_b = b;
    lat = 0; busy_n = 0; alu_seen = 1'b0; first_aluop = 4'hF; got_done = 1'b0;
    res = '0; dbz = 1'b0;
    while (!got_done && lat < 40) begin
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
      if (lat == inject_at) begin
        bus.start = 1'b1; bus.op = ~opv; bus.operand_a = 16'h0009; bus.operand_b = 16'h0000;
      end
      if (bus.busy) busy_n++;
      if (bus.alu_active && !alu_seen) begin
        alu_seen = 1'b1;
        first_aluop = bus.alu_operation;
      end
      if (bus.done) begin
        got_done = 1'b1;
        res = {bus.result_hi, bus.result_lo};
        dbz = bus.div_by_zero;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    post_busy = bus.busy;
    post_done = bus.done;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 1'b0; bus.operand_a = '0; bus.operand_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_flags", {28'd0, bus.busy, bus.done, bus.div_by_zero, bus.alu_active}, 32'd0);
    check("rst_result", {bus.result_hi, bus.result_lo}, 32'd0);
    check("rst_alu_opnds", {bus.alu_operand1, bus.alu_operand2}, 32'd0);
    check("rst_alu_op", {28'd0, bus.alu_operation}, 32'd0);
    reset = 1'b0;

    run_op(1'b0, 16'd3, 16'd5, 0);
    check("mul3x5_res", res, 32'h0000_000F);
    check("mul3x5_lat", lat, 17);
    check("mul3x5_busy", busy_n, 17);
    check("mul3x5_aluop", {28'd0, first_aluop}, 32'd0);
    check("mul3x5_dbz", {31'd0, dbz}, 32'd0);
    check("mul3x5_post", {30'd0, post_busy, post_done}, 32'd0);

    run_op(1'b0, 16'hFFFF, 16'hFFFF, 0);
    check("mulffff_res", res, 32'hFFFE_0001);
    check("mulffff_lat", lat, 17);

    run_op(1'b1, 16'd5, 16'd0, 0);
    check("div0_lat", lat, 1);
    check("div0_busy", busy_n, 1);
    check("div0_dbz", {31'd0, dbz}, 32'd1);
    check("div0_res", res, 32'h0005_FFFF);
    check("div0_active", {31'd0, alu_seen}, 32'd0);

    run_op(1'b1, 16'd100, 16'd7, 0);
    check("div100_7_res", res, 32'h0002_000E);
    check("div100_7_dbz", {31'd0, dbz}, 32'd0);
    check("div100_7_aluop", {28'd0, first_aluop}, 32'd1);
    check("div100_7_lat", lat, 17);

    run_op(1'b1, 16'hFFFF, 16'h0001, 0);
    check("divffff_1_res", res, 32'h0000_FFFF);

    // Second start arrives while cnt==4; it must neither disturb nor queue
    run_op(1'b0, 16'd3, 16'd5, 5);
    check("ign_res", res, 32'h0000_000F);
    check("ign_lat", lat, 17);
    check("ign_dbz", {31'd0, dbz}, 32'd0);
    check("ign_post", {30'd0, post_busy, post_done}, 32'd0);
    repeat (3) @(negedge clk);
    check("ign_hold", {bus.result_hi, bus.result_lo}, 32'h0000_000F);

    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.operand_a = 16'h1234; bus.operand_b = 16'h0003;
    lat = 0;
    while (lat < 9) begin
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
    end
    check("rstmid_running", {30'd0, bus.busy, bus.alu_active}, 32'd3);
    reset = 1'b1;
    #1;
    check("rstmid_flags", {29'd0, bus.busy, bus.done, bus.alu_active}, 32'd0);
    check("rstmid_result", {bus.result_hi, bus.result_lo}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op(1'b0, 16'd7, 16'd9, 0);
    check("mul7x9_res", res, 32'h0000_003F);
    check("mul7x9_lat", lat, 17);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
